// File: rtl/ic74x163_div_seq_if.sv
// Handshake and counter-control bundle between the divider sequencer and its environment.
// master: drives requests and the counter's rco feedback; slave: the sequencer itself.
interface ic74x163_div_seq_if #(
    parameter int unsigned CW = 8
);
    logic          start;
    logic          stop;
    logic [3:0]    div_n;
    logic [CW-1:0] burst_len;
    logic          rco_in;
    logic          ld_n;
    logic          enp;
    logic          ent;
    logic          a;
    logic          b;
    logic          c;
    logic          d;
    logic          busy;
    logic          tick;
    logic          done;
    logic          div_out;

    modport master (
        output start, stop, div_n, burst_len, rco_in,
        input  ld_n, enp, ent, a, b, c, d, busy, tick, done, div_out
    );

    modport slave (
        input  start, stop, div_n, burst_len, rco_in,
        output ld_n, enp, ent, a, b, c, d, busy, tick, done, div_out
    );
endinterface

// File: rtl/ic74x163_div_seq.sv
// Load/enable sequencer turning a 74x163-style counter into a modulo-N divider with burst support.
// Optional: define DIV_OUT_TOGGLE_EN to build the 50%-duty div_out toggle flop.
module ic74x163_div_seq #(
    parameter int unsigned CW = 8
) (
    input logic              clk,
    input logic              clr,
    ic74x163_div_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    div_q, div_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pre_q, pre_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic          rco_run;
    logic [CW-1:0] cnt_inc;
    logic          burst_hit;

    assign rco_run   = (state_q == RUN) && bus.rco_in;
    assign cnt_inc   = cnt_q + CW'(1);
    assign burst_hit = rco_run && (len_q != '0) && (cnt_inc == len_q);

    // State and output registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            div_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // Next state; stop outranks burst completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = LOAD;
            LOAD:    state_d = bus.stop ? IDLE : RUN;
            RUN:     if (bus.stop || burst_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and latched configuration
    always_comb begin
        div_d  = div_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if ((state_q == IDLE) && bus.start) begin
            div_d = bus.div_n;
            len_d = bus.burst_len;
            cnt_d = '0;
        end else if (rco_run) begin
            cnt_d = cnt_inc;
        end
        en_d   = (state_d == RUN);
        busy_d = (state_d != IDLE);
        // Preload (16 - div_n) mod 16: div_n = 0 gives divide-by-16
        pre_d  = busy_d ? (4'd0 - div_d) : 4'd0;
        tick_d = rco_run;
        done_d = burst_hit && !bus.stop;
    end

    // Reload in the same cycle the counter reaches 15
    assign bus.ld_n = (state_q == RUN) ? ~bus.rco_in : (state_q != LOAD);
    assign bus.enp  = en_q;
    assign bus.ent  = en_q;
    assign {bus.d, bus.c, bus.b, bus.a} = pre_q;
    assign bus.busy = busy_q;
    assign bus.tick = tick_q;
    assign bus.done = done_q;

`ifdef DIV_OUT_TOGGLE_EN
    logic divo_q, divo_d;

    always_comb begin
        divo_d = divo_q;
        if (state_d == IDLE) divo_d = 1'b0;
        else if (rco_run)    divo_d = ~divo_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) divo_q <= 1'b0;
        else      divo_q <= divo_d;
    end

    assign bus.div_out = divo_q;
`else
    assign bus.div_out = 1'b0;
`endif

endmodule

// File: tb/tb_ic74x163_div_seq.sv
// Self-checking bench: drives the sequencer with a 74x163 counter model attached and
// compares every cycle against an arithmetic period model of the divider.
module tb_ic74x163_div_seq;

    localparam int unsigned CW = 8;
    localparam logic [11:0] IDLE_VEC = 12'b1000_0000_0000;

    logic clk = 1'b0;
    logic clr;
    logic [3:0] cnt = 4'd0;
    int checks = 0;
    int errors = 0;

    ic74x163_div_seq_if #(.CW(CW)) bus ();

    ic74x163_div_seq #(.CW(CW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // 74x163 counter: synchronous load, count when enp & ent, rco = ent & (Q == 15)
    always @(posedge clk) begin
        if (!bus.ld_n)              cnt <= {bus.d, bus.c, bus.b, bus.a};
        else if (bus.enp && bus.ent) cnt <= cnt + 4'd1;
    end
    assign bus.rco_in = bus.ent && (cnt == 4'd15);

    // rco expected in RUN cycle k (k = 0 at RUN entry) for divide ratio dv (1..16)
    function automatic logic rco_at(input int dv, input int k);
        return (k >= dv - 1) && (((k - (dv - 1)) % dv) == 0);
    endfunction

    // Number of completed periods up to and including RUN cycle k
    function automatic int periods_at(input int dv, input int k);
        return (k < dv - 1) ? 0 : ((k - (dv - 1)) / dv + 1);
    endfunction

    // Cycle index (LOAD = 0) of the IDLE cycle following a natural burst end
    function automatic int nat_end(input int dv, input int len);
        return (dv - 1) + (len - 1) * dv + 2;
    endfunction

    function automatic int burst_end(input int dv, input int len, input int stop_t);
        int nat;
        nat = (len != 0) ? nat_end(dv, len) : 2000;
        if (stop_t >= 0 && stop_t + 1 < nat) return stop_t + 1;
        return nat;
    endfunction

    // Expected {ld_n,enp,ent,d,c,b,a,busy,tick,done,div_out,rco_in} at cycle t
    function automatic logic [11:0] model(input int dv, input int len, input int stop_t,
                                          input int end_t, input int t);
        logic [3:0] p;
        logic       rco, tk, dn, dvo;
        int         k;
        p = 4'((16 - dv) % 16);
        if (t == 0) return {3'b000, p, 1'b1, 4'b0000};
        if (t == end_t) begin
            tk = (end_t >= 2) && rco_at(dv, end_t - 2);
            dn = (len != 0) && (end_t == nat_end(dv, len)) && (stop_t != end_t - 1);
            return {1'b1, 2'b00, 4'h0, 1'b0, tk, dn, 2'b00};
        end
        k   = t - 1;
        rco = rco_at(dv, k);
        tk  = (k >= 1) && rco_at(dv, k - 1);
`ifdef DIV_OUT_TOGGLE_EN
        dvo = (k >= 1) && ((periods_at(dv, k - 1) % 2) == 1);
`else
        dvo = 1'b0;
`endif
        return {~rco, 2'b11, p, 1'b1, tk, 1'b0, dvo, rco};
    endfunction

    function automatic logic [11:0] observe();
        return {bus.ld_n, bus.enp, bus.ent, bus.d, bus.c, bus.b, bus.a,
                bus.busy, bus.tick, bus.done, bus.div_out, bus.rco_in};
    endfunction

    // Starts a run at the current negedge and checks it through its first IDLE cycle
    task automatic run_burst(input int div, input int len, input int stop_t, input bit junk,
                             output int ticks, output int dones);
        int dv, end_t;
        logic [11:0] obs, exp_v;
        dv    = (div == 0) ? 16 : div;
        end_t = burst_end(dv, len, stop_t);
        ticks = 0;
        dones = 0;
        bus.div_n     = 4'(div);
        bus.burst_len = CW'(len);
        bus.start     = 1'b1;
        bus.stop      = 1'b0;
        @(negedge clk);
        for (int t = 0; t <= end_t; t++) begin
            obs   = observe();
            exp_v = model(dv, len, stop_t, end_t, t);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL burst div=%0d len=%0d stop_t=%0d t=%0d: got %b expected %b",
                         div, len, stop_t, t, obs, exp_v);
            end
            if (bus.tick) ticks++;
            if (bus.done) dones++;
            bus.start = 1'b0;
            bus.stop  = (t == stop_t);
            if (junk && t < end_t && $urandom_range(0, 2) == 0) begin
                bus.start     = 1'b1;
                bus.div_n     = 4'($urandom);
                bus.burst_len = CW'($urandom);
            end
            if (t < end_t) @(negedge clk);
        end
        bus.stop = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        logic [11:0] obs;
        for (int i = 0; i < n; i++) begin
            bus.stop = 1'($urandom);
            @(negedge clk);
            obs = observe();
            checks++;
            if (obs !== IDLE_VEC) begin
                errors++;
                $display("FAIL idle cycle %0d: got %b expected %b", i, obs, IDLE_VEC);
            end
        end
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs;
        clr           = 1'b0;
        bus.start     = 1'b1;
        bus.stop      = 1'b0;
        bus.div_n     = 4'd9;
        bus.burst_len = CW'(2);
        repeat (3) @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset held: got %b expected %b", obs, IDLE_VEC);
        end
        clr       = 1'b1;
        bus.start = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_continuous();
        int ticks, dones;
        run_burst(10, 0, 55, 1'b0, ticks, dones);
        checks++;
        if (ticks != 5 || dones != 0) begin
            errors++;
            $display("FAIL continuous div10: ticks=%0d dones=%0d expected 5 and 0", ticks, dones);
        end
        idle_cycles(2);
    endtask

    task automatic test_div16_burst();
        int ticks, dones;
        run_burst(0, 3, -1, 1'b0, ticks, dones);
        checks++;
        if (ticks != 3 || dones != 1) begin
            errors++;
            $display("FAIL div16 burst3: ticks=%0d dones=%0d expected 3 and 1", ticks, dones);
        end
        idle_cycles(2);
    endtask

    task automatic test_div1_burst();
        int ticks, dones;
        run_burst(1, 4, -1, 1'b1, ticks, dones);
        checks++;
        if (ticks != 4 || dones != 1) begin
            errors++;
            $display("FAIL div1 burst4: ticks=%0d dones=%0d expected 4 and 1", ticks, dones);
        end
        idle_cycles(2);
    endtask

    task automatic test_stop_on_rco();
        int ticks, dones;
        // rco at RUN cycles 4 and 9; stop lands on the second (t = 10)
        run_burst(5, 0, 10, 1'b1, ticks, dones);
        checks++;
        if (ticks != 2 || dones != 0) begin
            errors++;
            $display("FAIL stop on rco: ticks=%0d dones=%0d expected 2 and 0", ticks, dones);
        end
        run_burst(6, 2, 0, 1'b0, ticks, dones);
        checks++;
        if (ticks != 0 || dones != 0) begin
            errors++;
            $display("FAIL stop in load: ticks=%0d dones=%0d expected 0 and 0", ticks, dones);
        end
        idle_cycles(2);
    endtask

    task automatic test_div_out();
        int ticks, dones;
        run_burst(4, 0, 20, 1'b0, ticks, dones);
        checks++;
        if (ticks != 5) begin
            errors++;
            $display("FAIL div4 continuous: ticks=%0d expected 5", ticks);
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        int t1, d1, t2, d2;
        run_burst(3, 2, -1, 1'b0, t1, d1);
        run_burst(7, 1, -1, 1'b1, t2, d2);
        checks++;
        if (t1 + t2 != 3 || d1 + d2 != 2) begin
            errors++;
            $display("FAIL back to back: ticks=%0d dones=%0d expected 3 and 2", t1 + t2, d1 + d2);
        end
        idle_cycles(1);
    endtask

    task automatic test_clr_mid_run();
        logic [11:0] obs;
        bus.div_n     = 4'd7;
        bus.burst_len = CW'(0);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        #2 clr = 1'b0;
        #1 obs = observe();
        checks++;
        if (obs !== IDLE_VEC) begin
            errors++;
            $display("FAIL clr mid run: got %b expected %b", obs, IDLE_VEC);
        end
        @(negedge clk);
        clr = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_random();
        int div, len, stop_t, ticks, dones;
        for (int i = 0; i < 10; i++) begin
            div    = $urandom_range(0, 15);
            len    = $urandom_range(0, 3);
            stop_t = (len == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(0, 50) : -1;
            run_burst(div, len, stop_t, 1'b1, ticks, dones);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.div_n     = 4'd0;
        bus.burst_len = '0;
        test_reset();
        test_continuous();
        test_div16_burst();
        test_div1_burst();
        test_stop_on_rco();
        test_div_out();
        test_back_to_back();
        test_clr_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic74x163_div_seq.md
Name: ic74x163_div_seq

Overview:
- Upstream load/enable sequencer for a 74x163-style 4-bit synchronous counter (or the least-significant stage of a cascade).
- Drives the counter's ld_n, enp, ent and preload data a..d, and takes the counter's rco back as feedback, so the counter becomes a programmable modulo-N divider.
- Supports continuous or burst operation (a fixed number of periods), with tick/done/busy status for downstream logic.

Parameters:
CW, 8, width of burst_len and the internal period counter

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  asynchronous, active-low reset
start  in  1  start request; sampled only in IDLE
stop  in  1  abort request; sampled only in LOAD/RUN
div_n  in  4  divide ratio 1..15; 0 encodes 16; latched at start
burst_len  in  CW  number of rco periods before auto-stop; 0 = continuous; latched at start
rco_in  in  1  ripple-carry feedback from the counter
ld_n  out  1  counter synchronous load, active-low
enp  out  1  counter count enable P
ent  out  1  counter count enable T
a,b,c,d  out  1 each  preload data, a = LSB
busy  out  1  high in LOAD and RUN
tick  out  1  one-cycle pulse per completed divider period
done  out  1  one-cycle pulse when a burst completes
div_out  out  1  divided clock-enable output (see Optional Feature)

Behaviour:
- Reset (clr low, async) forces:
  - state = IDLE
  - ld_n = 1; enp = ent = 0; a..d = 0
  - busy = tick = done = div_out = 0
  - latched div_n and burst_len = 0; period count = 0
- Preload value: P = (16 - div_n) mod 16, 4 bits. For div_n = 0, P = 0 (divide by 16). For div_n = 1, P = 15 (divide by 1).
- a..d hold P, registered, from LOAD onward. They return to 0 in IDLE.
- IDLE:
  - Outputs are at their reset values.
  - rco_in and stop are ignored.
  - On start = 1: latch div_n and burst_len, clear the period count, go to LOAD.
- LOAD (exactly 1 cycle):
  - ld_n = 0, enp = ent = 0, busy = 1.
  - Always goes to RUN next cycle.
  - stop = 1 in LOAD goes to IDLE instead (no done).
- RUN:
  - enp = ent = 1, busy = 1.
  - ld_n = ~rco_in. This is the only combinational output path; the counter reloads P in the same cycle its count reaches 15.
  - The first rco_in is expected div_n-1 cycles after RUN entry; after that, one rco_in every div_n cycles.
  - On each cycle with rco_in = 1:
    - period count increments, wrapping modulo 2^CW;
    - tick = 1 in the next cycle (registered).
  - If burst_len != 0 and the incremented count equals burst_len:
    - ld_n is still 0 in that cycle (reload completes);
    - next cycle: state = IDLE, done = 1 for one cycle, tick = 1 for that same cycle.
  - stop = 1 goes to IDLE next cycle, with no done.
    - If stop and rco_in are both 1 in the same cycle, the reload still occurs (ld_n = 0) and tick still pulses; stop wins over burst completion, so done = 0.
- start while busy is ignored. div_n and burst_len changes while busy are ignored.
- Back-to-back bursts: start in the cycle done = 1 is accepted (state is IDLE by then) and goes to LOAD.
- clr asserted mid-RUN returns every output to its reset value immediately.

Optional Feature:
- Macro DIV_OUT_TOGGLE_EN.
- Defined:
  - div_out toggles (registered) on every rco_in = 1 sampled in RUN, giving a period of 2*div_n cycles and a 50% duty cycle for even periods;
  - div_out is forced to 0 on entering IDLE.
- Undefined: div_out is tied to 0 and the toggle flop is not built.

Test Plan:
- Reset: clr = 0 with start = 1 -> all outputs 0, ld_n = 1, state IDLE; release clr -> still IDLE until start is sampled.
- div_n = 10, burst_len = 0, start pulse, counter model attached -> one LOAD cycle with a..d = 6 (d..a = 0110); rco_in every 10 cycles; tick every 10 cycles; ld_n low only in the rco cycles; done never asserts.
- div_n = 0, burst_len = 3 -> P = 0; rco_in at RUN cycles 15, 31, 47; done = 1 one cycle after the third rco_in; then IDLE with enp = ent = 0 and a..d = 0.
- div_n = 1, burst_len = 4 -> P = 15; rco_in every RUN cycle; ld_n = 0 throughout RUN; exactly 4 ticks, then done.
- stop asserted in the same cycle as rco_in during RUN with div_n = 5 -> ld_n = 0 in that cycle, tick = 1 in the next cycle, done = 0, IDLE next cycle; a start pulse while busy earlier in the run is shown to have no effect.
- With DIV_OUT_TOGGLE_EN defined, div_n = 4, continuous -> div_out toggles every 4 cycles (period 8); stop -> div_out = 0 in IDLE. With it undefined -> div_out is constant 0.
